seq_restoring_divider: RTL and testbench

- Iterative unsigned divider for the arithmetic datapath. It computes quotient and remainder by repeated shift-and-subtract, one trial subtraction per clock.
- It is the consumer of the team's subtract datapath: each trial subtraction is a WIDTH-bit subtract with borrow.
- Operands are handed over with a start/busy/done handshake from the control sequencer.

---
 rtl/seq_restoring_divider_pkg.sv | 14 +
 rtl/seq_restoring_divider_trial_subtract.sv | 22 ++
 rtl/seq_restoring_divider.sv | 119 +++++++++++
 tb/tb_seq_restoring_divider.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state enum and the divide-by-zero quotient pattern.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Sliced down to WIDTH by the user.
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/seq_restoring_divider_trial_subtract.sv
// One trial subtraction: minuend(W+1) - {0,subtrahend(W)}.
// Ports: minuend_i, subtrahend_i in; diff_o, borrow_o out.
module trial_subtract #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   minuend_i,
  input  logic [WIDTH-1:0] subtrahend_i,
  output logic [WIDTH:0]   diff_o,
  output logic             borrow_o
);

  logic [WIDTH+1:0] sum;

  // Invert plus carry-in; carry-out set means no borrow.
  assign sum = {1'b0, minuend_i}
             + {1'b0, ~{1'b0, subtrahend_i}}
             + (WIDTH+2)'(1);

  assign diff_o   = sum[WIDTH:0];
  assign borrow_o = ~sum[WIDTH+1];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one trial subtract per clock.
// Ports: clk, rst_n, start, dividend, divisor in; busy, done,
// quotient, remainder, div_by_zero out.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             unused_rtop;

  // R never exceeds D after a restore, so its top bit is shifted out.
  assign r_sh        = {r_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign unused_rtop = r_q[WIDTH];

  trial_subtract #(
    .WIDTH(WIDTH)
  ) u_sub (
    .minuend_i   (r_sh),
    .subtrahend_i(d_q),
    .diff_o      (diff),
    .borrow_o    (borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    qr_d    = qr_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          d_d     = divisor;
          qr_d    = dividend;
          r_d     = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      RUN: begin
        if (d_q == '0) begin
          state_d = DONE;
          quot_d  = DBZ_QUOT[WIDTH-1:0];
          rem_d   = qr_q;
          dbz_d   = 1'b1;
        end else begin
          r_d   = borrow ? r_sh : diff;
          qr_d  = {qr_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DONE;
            quot_d  = qr_d;
            rem_d   = r_d[WIDTH-1:0];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      qr_q    <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      qr_q    <= qr_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider.
// Directed table, handshake corners, async reset, random sweep.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  seq_restoring_divider #(.WIDTH(W), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input string name);
    int lat;
    int want_lat;
    lat = 0;
    want_lat = (dv == 0) ? 1 : W;
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, ".busy"}, busy, 1);
    for (int k = 1; k <= 20; k++) begin
      if (lat == 0) begin
        @(posedge clk);
        #1;
        if (done) lat = k;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout got=none want=done", name);
    end else begin
      check({name, ".lat"}, lat, want_lat);
      check({name, ".q"}, quotient, eq);
      check({name, ".r"}, remainder, er);
      check({name, ".dbz"}, div_by_zero, ez);
      if (!ez)
        check({name, ".inv"},
              (longint'(quotient) * dv + remainder == dd) &&
              (remainder < dv), 1);
      @(posedge clk);
      #1;
      check({name, ".pulse"}, done, 0);
      check({name, ".idle"}, busy, 0);
    end
  endtask

  initial begin
    tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    tbl[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    tbl[3] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    tbl[4] = '{8'd77,  8'd0,   8'hFF,  8'd77, 1'b1};
    tbl[5] = '{8'd77,  8'd5,   8'd15,  8'd2,  1'b0};
    tbl[6] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
    tbl[7] = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0};
    tbl[8] = '{8'd200, 8'd3,   8'd66,  8'd2,  1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.q", quotient, 0);
    check("rst.r", remainder, 0);
    check("rst.dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_op(tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, tbl[i].z,
             $sformatf("vec%0d", i));

    // start pulses during RUN (edge 3) and DONE (edge 9) are ignored
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 3 || e == 9) begin
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd4;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e == 8) begin
        check("ign.done", done, 1);
        check("ign.q", quotient, 66);
        check("ign.r", remainder, 2);
      end
    end
    check("ign.busy_fall", busy, 0);
    check("ign.no_redone", done, 0);
    @(posedge clk);
    #1;
    check("ign.stay_idle", busy, 0);
    check("ign.hold_q", quotient, 66);

    // asynchronous abort between edges 4 and 5
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.q", quotient, 0);
    check("abort.r", remainder, 0);
    check("abort.dbz", div_by_zero, 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk);
        #1;
        if (done) seen++;
        if (k == 3) rst_n = 1'b1;
      end
      check("abort.no_done", seen, 0);
    end
    run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, "post_abort");

    for (int n = 0; n < 2000; n++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (n % 16 == 0) a = '0;
      if (n % 64 == 5) b = '0;
      if (b == 0)
        run_op(a, b, 8'hFF, a, 1'b1, "rand");
      else
        run_op(a, b, a / b, a % b, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
